// File: rtl/shared_pkg.sv
// Shared APB definitions: bus widths, default requester count, the APB
// master state encoding and the registered request payload struct.
package shared_pkg;
  localparam int ADDR_WIDTH      = 32;
  localparam int DATA_WIDTH      = 32;
  localparam int PSTRB_WIDTH     = DATA_WIDTH / 8;
  localparam int NUM_REQ_DEFAULT = 2;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} apb_state_e;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0]  addr;
    logic                   write;
    logic [DATA_WIDTH-1:0]  wdata;
    logic [PSTRB_WIDTH-1:0] strb;
    logic [2:0]             prot;
  } apb_req_t;
endpackage

// File: rtl/apb_rr_arbiter.sv
// Round-robin arbiter with a rotating priority pointer.
//   clk, rst_n : clock, async active-low reset (pointer -> 0)
//   req        : request vector
//   en         : grant enable; pointer advances only on an enabled grant
//   gnt        : one-hot grant (zero when en=0 or no request)
//   gnt_idx    : index of the winning requester (valid when |req)
// The pointer names the highest-priority requester; after a grant it moves
// to the slot just past the winner so the winner becomes lowest priority.
module apb_rr_arbiter
  import shared_pkg::*;
#(
  parameter  int NUM_REQ = NUM_REQ_DEFAULT,
  localparam int IDXW    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic               en,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDXW-1:0]    gnt_idx
);
  logic [IDXW-1:0] ptr;
  logic            found;

  always_comb begin
    gnt_idx = '0;
    found   = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!found && req[(int'(ptr) + k) % NUM_REQ]) begin
        found   = 1'b1;
        gnt_idx = IDXW'((int'(ptr) + k) % NUM_REQ);
      end
    end
    gnt = '0;
    if (en && found) gnt[gnt_idx] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      ptr <= '0;
    else if (en && found)
      ptr <= (int'(gnt_idx) == NUM_REQ - 1) ? '0 : gnt_idx + IDXW'(1);
  end
endmodule

// File: rtl/apb_master_arbiter.sv
// APB master shared by NUM_REQ local requesters. Round-robin arbitration,
// IDLE/SETUP/ACCESS sequencing, response routed back to the owner.
//   clk, PRESETn        : clock, async active-low reset
//   req_*               : flattened per-requester request (slice i = requester i)
//   req_ready           : one-hot acceptance, combinational in the grant cycle
//   rsp_valid/rdata/slverr : one-cycle completion pulse to the owner
//   PSELx..PPROT        : APB master outputs (registered)
//   PRDATA/PREADY/PSLVERR : APB slave response
// Optional feature macro: APB_TIMEOUT_EN -- ends an ACCESS phase that has
// waited TIMEOUT_CYCLES cycles with PREADY=0, reporting slverr=1, rdata=0.
module apb_master_arbiter
  import shared_pkg::*;
#(
  parameter int NUM_REQ        = NUM_REQ_DEFAULT,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                           clk,
  input  logic                           PRESETn,
  input  logic [NUM_REQ-1:0]             req_valid,
  output logic [NUM_REQ-1:0]             req_ready,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]  req_addr,
  input  logic [NUM_REQ-1:0]             req_write,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_wdata,
  input  logic [NUM_REQ*PSTRB_WIDTH-1:0] req_strb,
  input  logic [NUM_REQ*3-1:0]           req_prot,
  output logic [NUM_REQ-1:0]             rsp_valid,
  output logic [DATA_WIDTH-1:0]          rsp_rdata,
  output logic                           rsp_slverr,
  output logic                           PSELx,
  output logic                           PENABLE,
  output logic                           PWRITE,
  output logic [ADDR_WIDTH-1:0]          PADDR,
  output logic [DATA_WIDTH-1:0]          PWDATA,
  output logic [PSTRB_WIDTH-1:0]         PSTRB,
  output logic [2:0]                     PPROT,
  input  logic [DATA_WIDTH-1:0]          PRDATA,
  input  logic                           PREADY,
  input  logic                           PSLVERR
);
  localparam int IDXW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  apb_state_e      state;
  apb_req_t        pay, sel;
  logic [IDXW-1:0] owner, gnt_idx;
  logic [NUM_REQ-1:0] gnt;
  logic            any_req, timeout, done, arb_en;

  // Packed per-requester views of the flattened request buses
  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0]  addr_v;
  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]  wdata_v;
  logic [NUM_REQ-1:0][PSTRB_WIDTH-1:0] strb_v;
  logic [NUM_REQ-1:0][2:0]             prot_v;

  assign addr_v  = req_addr;
  assign wdata_v = req_wdata;
  assign strb_v  = req_strb;
  assign prot_v  = req_prot;

  assign sel = '{addr:  addr_v[gnt_idx],  write: req_write[gnt_idx],
                 wdata: wdata_v[gnt_idx], strb:  strb_v[gnt_idx],
                 prot:  prot_v[gnt_idx]};

  assign any_req = |req_valid;
  assign done    = PREADY | timeout;
  // Grant only when the bus is free now or frees at this edge
  assign arb_en  = (state == IDLE) || (state == ACCESS && done);

  apb_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .clk     (clk),
    .rst_n   (PRESETn),
    .req     (req_valid),
    .en      (arb_en),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  assign req_ready = PRESETn ? gnt : '0;

  assign PADDR  = pay.addr;
  assign PWRITE = pay.write;
  assign PWDATA = pay.wdata;
  assign PSTRB  = pay.strb;
  assign PPROT  = pay.prot;

`ifdef APB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] to_cnt;

  // Fires in the TIMEOUT_CYCLES-th consecutive wait cycle of ACCESS
  assign timeout = (state == ACCESS) && !PREADY &&
                   (int'(to_cnt) == TIMEOUT_CYCLES - 1);

  always_ff @(posedge clk or negedge PRESETn) begin
    if (!PRESETn)                      to_cnt <= '0;
    else if (state == SETUP)           to_cnt <= '0;
    else if (state == ACCESS && !PREADY) to_cnt <= to_cnt + TW'(1);
  end
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge PRESETn) begin
    if (!PRESETn) begin
      state      <= IDLE;
      pay        <= '0;
      owner      <= '0;
      PSELx      <= 1'b0;
      PENABLE    <= 1'b0;
      rsp_valid  <= '0;
      rsp_rdata  <= '0;
      rsp_slverr <= 1'b0;
    end else begin
      rsp_valid <= '0;
      case (state)
        IDLE: if (any_req) begin
          pay   <= sel;
          owner <= gnt_idx;
          PSELx <= 1'b1;
          state <= SETUP;
        end
        SETUP: begin
          PENABLE <= 1'b1;
          state   <= ACCESS;
        end
        ACCESS: if (done) begin
          rsp_valid  <= NUM_REQ'(1) << owner;
          rsp_rdata  <= (timeout || pay.write) ? '0 : PRDATA;
          rsp_slverr <= timeout | PSLVERR;
          PENABLE    <= 1'b0;
          // Back-to-back: stay selected and go straight to SETUP
          if (any_req) begin
            pay   <= sel;
            owner <= gnt_idx;
            state <= SETUP;
          end else begin
            PSELx <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
